// File: rtl/alu_mc.sv
// alu_mc: multicycle ALU with a start/busy/done handshake.
// MUL is an N-step shift-add (unless MUL_FAST), DIV an N-step restoring divider.
module alu_mc #(
  parameter int N           = 16,
  parameter int OP_W        = 4,
  parameter int FLAGS_COUNT = 4,
  parameter int MUL_FAST    = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N-1:0]           a,
  input  logic [N-1:0]           b,
  input  logic [OP_W-1:0]        opcode,
  input  logic                   start,
  output logic [N-1:0]           result,
  output logic [N-1:0]           high,
  output logic [FLAGS_COUNT-1:0] flags,
  output logic                   busy,
  output logic                   done
);

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_P = 3;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(4);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(7);
  localparam logic [OP_W-1:0] OP_INV = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(10);
  localparam logic [OP_W-1:0] OP_NEG = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ADC = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SBC = OP_W'(13);
  localparam logic [OP_W-1:0] OP_ASR = OP_W'(14);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(15);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_e;

  function automatic logic [FLAGS_COUNT-1:0] mk_flags(input logic [N-1:0] r,
                                                      input logic c, input logic v);
    logic [FLAGS_COUNT-1:0] f;
    f         = {FLAGS_COUNT{1'b0}};
    f[FLAG_Z] = (r == {N{1'b0}});
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_P] = ~r[N-1];
    return f;
  endfunction

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N-1:0]           work_hi_q, work_hi_d, work_lo_q, work_lo_d, opnd_q, opnd_d;
  logic [N-1:0]           result_q, result_d, high_q, high_d;
  logic [FLAGS_COUNT-1:0] flags_q, flags_d;
  logic                   busy_q, busy_d, done_q, done_d;

  logic [N:0]             add_s, sub_s, neg_s, shl_s, shr_s, asr_s;
  logic [2*N-1:0]         prod_s;
  logic                   add_v_s, sub_v_s, neg_v_s;
  logic [N-1:0]           sc_result_s, sc_high_s;
  logic [FLAGS_COUNT-1:0] sc_flags_s;

  logic [N:0]             mul_sum_s, div_sh_s;
  logic [N-1:0]           mul_hi_s, mul_lo_s, div_sub_s, div_rem_s, div_quo_s;
  logic                   div_ge_s, last_s;

  // Iterative datapath: {work_hi,work_lo} is the product for MUL, {remainder,quotient} for DIV.
  assign mul_sum_s = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
  assign mul_hi_s  = mul_sum_s[N:1];
  assign mul_lo_s  = {mul_sum_s[0], work_lo_q[N-1:1]};
  assign div_sh_s  = {work_hi_q, work_lo_q[N-1]};
  assign div_ge_s  = (div_sh_s >= {1'b0, opnd_q});
  assign div_sub_s = div_sh_s[N-1:0] - opnd_q;
  assign div_rem_s = div_ge_s ? div_sub_s : div_sh_s[N-1:0];
  assign div_quo_s = {work_lo_q[N-2:0], div_ge_s};
  assign last_s    = (cnt_q == CNT_W'(N-1));

  // Single-cycle results, flags and fast-path MUL / divide-by-zero outcome.
  always_comb begin
    add_s   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, (opcode == OP_ADC) & flags_q[FLAG_C]};
    sub_s   = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, (opcode == OP_SBC) & flags_q[FLAG_C]};
    neg_s   = {(N+1){1'b0}} - {1'b0, b};
    shl_s   = {1'b0, a} << b;
    shr_s   = {a, 1'b0} >> b;
    asr_s   = $signed({a, 1'b0}) >>> b;
    prod_s  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    add_v_s = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
    sub_v_s = (a[N-1] != b[N-1]) && (sub_s[N-1] != a[N-1]);
    neg_v_s = b[N-1] && neg_s[N-1];
    sc_result_s = result_q;
    sc_high_s   = high_q;
    sc_flags_s  = flags_q;
    case (opcode)
      OP_NOP: sc_result_s = result_q;
      OP_ADD, OP_ADC: begin
        sc_result_s = add_s[N-1:0];
        sc_flags_s  = mk_flags(add_s[N-1:0], add_s[N], add_v_s);
      end
      OP_SUB, OP_SBC: begin
        sc_result_s = sub_s[N-1:0];
        sc_flags_s  = mk_flags(sub_s[N-1:0], sub_s[N], sub_v_s);
      end
      OP_CMP: sc_flags_s = mk_flags(sub_s[N-1:0], sub_s[N], sub_v_s);
      OP_NEG: begin
        sc_result_s = neg_s[N-1:0];
        sc_flags_s  = mk_flags(neg_s[N-1:0], neg_s[N], neg_v_s);
      end
      OP_MUL: begin
        sc_result_s = prod_s[N-1:0];
        sc_high_s   = prod_s[2*N-1:N];
        sc_flags_s  = mk_flags(prod_s[N-1:0], 1'b0, prod_s[2*N-1:N] != {N{1'b0}});
      end
      // Only reaches the output path when b==0; nonzero divisors run iteratively.
      OP_DIV: begin
        sc_result_s = {N{1'b1}};
        sc_high_s   = a;
        sc_flags_s  = mk_flags({N{1'b1}}, 1'b0, 1'b1);
      end
      OP_AND: begin
        sc_result_s = a & b;
        sc_flags_s  = mk_flags(a & b, 1'b0, 1'b0);
      end
      OP_OR: begin
        sc_result_s = a | b;
        sc_flags_s  = mk_flags(a | b, 1'b0, 1'b0);
      end
      OP_XOR: begin
        sc_result_s = a ^ b;
        sc_flags_s  = mk_flags(a ^ b, 1'b0, 1'b0);
      end
      OP_INV: begin
        sc_result_s = ~a;
        sc_flags_s  = mk_flags(~a, 1'b0, 1'b0);
      end
      OP_SHL: begin
        sc_result_s = shl_s[N-1:0];
        sc_flags_s  = mk_flags(shl_s[N-1:0], shl_s[N], 1'b0);
      end
      OP_SHR: begin
        sc_result_s = shr_s[N:1];
        sc_flags_s  = mk_flags(shr_s[N:1], shr_s[0], 1'b0);
      end
      OP_ASR: begin
        sc_result_s = asr_s[N:1];
        sc_flags_s  = mk_flags(asr_s[N:1], asr_s[0], 1'b0);
      end
      default: sc_result_s = result_q;
    endcase
  end

  // Control FSM: accept in IDLE, iterate in MUL/DIV, publish outputs on completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    high_d    = high_q;
    flags_d   = flags_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((opcode == OP_MUL) && (MUL_FAST == 0)) begin
            state_d   = ST_MUL;
            busy_d    = 1'b1;
            cnt_d     = {CNT_W{1'b0}};
            work_hi_d = {N{1'b0}};
            work_lo_d = b;
            opnd_d    = a;
          end else if ((opcode == OP_DIV) && (b != {N{1'b0}})) begin
            state_d   = ST_DIV;
            busy_d    = 1'b1;
            cnt_d     = {CNT_W{1'b0}};
            work_hi_d = {N{1'b0}};
            work_lo_d = a;
            opnd_d    = b;
          end else begin
            result_d = sc_result_s;
            high_d   = sc_high_s;
            flags_d  = sc_flags_s;
            done_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        work_hi_d = (state_q == ST_MUL) ? mul_hi_s : div_rem_s;
        work_lo_d = (state_q == ST_MUL) ? mul_lo_s : div_quo_s;
        if (last_s) begin
          result_d = work_lo_d;
          high_d   = work_hi_d;
          flags_d  = mk_flags(work_lo_d, 1'b0,
                              (state_q == ST_MUL) && (work_hi_d != {N{1'b0}}));
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      work_hi_q <= {N{1'b0}};
      work_lo_q <= {N{1'b0}};
      opnd_q    <= {N{1'b0}};
      result_q  <= {N{1'b0}};
      high_q    <= {N{1'b0}};
      flags_q   <= {FLAGS_COUNT{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
      high_q    <= high_d;
      flags_q   <= flags_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign result = result_q;
  assign high   = high_q;
  assign flags  = flags_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc (N=16, iterative MUL) against an
// arithmetic reference model; directed cases cover timing, reset abort and edge values.
module tb_alu_mc;
  localparam int N = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [N-1:0]  a, b;
  logic [3:0]    opcode;
  logic          start;
  logic [N-1:0]  result, high;
  logic [3:0]    flags;
  logic          busy, done;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] m_res, m_high;
  logic [3:0]  m_flags;
  int          m_lat;

  alu_mc #(.N(N), .OP_W(4), .FLAGS_COUNT(4), .MUL_FAST(0)) dut (
    .CLK(CLK), .RESET(RESET), .a(a), .b(b), .opcode(opcode), .start(start),
    .result(result), .high(high), .flags(flags), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ovf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  // Reference model: plain integer arithmetic on the operation rules.
  task automatic model(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib);
    int x, y, sa, sb, cin;
    longint p;
    logic [15:0] r, d;
    logic c, v;
    x = int'(ia); y = int'(ib);
    sa = int'($signed(ia)); sb = int'($signed(ib));
    cin = int'(m_flags[1]);
    r = m_res; c = 1'b0; v = 1'b0; m_lat = 0;
    case (op)
      4'd0: return;
      4'd1, 4'd12: begin
        p = longint'(x) + longint'(y) + ((op == 4'd12) ? longint'(cin) : 64'sd0);
        r = p[15:0]; c = p[16];
        v = ovf(sa + sb + ((op == 4'd12) ? cin : 0));
      end
      4'd2, 4'd13: begin
        if (op == 4'd2) cin = 0;
        r = 16'(x - y - cin); c = (x < y + cin); v = ovf(sa - sb - cin);
      end
      4'd15: begin
        d = 16'(x - y);
        m_flags = {~d[15], ovf(sa - sb), (x < y), (d == 16'h0)};
        return;
      end
      4'd11: begin r = 16'(0 - y); c = (y != 0); v = ovf(0 - sb); end
      4'd3: begin
        p = longint'(x) * longint'(y);
        r = p[15:0]; m_high = p[31:16]; v = (p[31:16] != 16'h0); m_lat = 16;
      end
      4'd4: begin
        if (y == 0) begin r = 16'hFFFF; m_high = ia; v = 1'b1; end
        else begin r = 16'(x / y); m_high = 16'(x % y); m_lat = 16; end
      end
      4'd5: r = ia & ib;
      4'd6: r = ia | ib;
      4'd7: r = ia ^ ib;
      4'd8: r = ~ia;
      4'd9: begin
        r = (y >= 16) ? 16'h0 : 16'(x << y);
        c = (y == 0 || y > 16) ? 1'b0 : ia[16 - y];
      end
      4'd10: begin
        r = (y >= 16) ? 16'h0 : 16'(x >> y);
        c = (y == 0 || y > 16) ? 1'b0 : ia[y - 1];
      end
      4'd14: begin
        r = (y >= 16) ? {16{ia[15]}} : 16'(sa >>> y);
        c = (y == 0) ? 1'b0 : (y > 16) ? ia[15] : ia[y - 1];
      end
      default: return;
    endcase
    m_res = r;
    m_flags = {~r[15], v, c, (r == 16'h0)};
  endtask

  // Issue one op at a negedge, wait (bounded) for done, check timing and outputs.
  task automatic run_op(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                        input string tag, input int inject);
    int edges, busy_n;
    model(op, ia, ib);
    opcode = op; a = ia; b = ib; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    edges = 0; busy_n = 0;
    while (!done && edges < 64) begin
      if (busy) busy_n++;
      start = (edges == inject);
      if (edges == inject) opcode = 4'd1;
      @(negedge CLK);
      edges++;
    end
    start = 1'b0;
    check({tag, "_lat"}, edges, m_lat);
    check({tag, "_busycyc"}, busy_n, m_lat);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res"}, result, m_res);
    check({tag, "_high"}, high, m_high);
    check({tag, "_flags"}, flags, m_flags);
  endtask

  initial begin
    int quiet;
    logic [3:0] op;
    logic [15:0] ia, ib;
    RESET = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; opcode = 4'd0;
    m_res = 16'h0; m_high = 16'h0; m_flags = 4'h0; m_lat = 0;
    repeat (2) @(negedge CLK);
    check("rst_res", result, 0); check("rst_high", high, 0); check("rst_flags", flags, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    RESET = 1'b0;
    @(negedge CLK);

    run_op(4'd1, 16'h7FFF, 16'h0001, "add_ovf", -1);
    check("add_ovf_k", {result, 12'h0, flags}, {16'h8000, 12'h0, 4'b0100});
    run_op(4'd15, 16'd5, 16'd5, "cmp_eq", -1);
    check("cmp_eq_k", {result, 12'h0, flags}, {16'h8000, 12'h0, 4'b1001});
    run_op(4'd1, 16'hFFFF, 16'h0001, "add_wrap", -1);
    check("add_wrap_k", {result, 12'h0, flags}, {16'h0000, 12'h0, 4'b1011});
    run_op(4'd12, 16'h0, 16'h0, "adc", -1);
    check("adc_k", {result, 12'h0, flags}, {16'h0001, 12'h0, 4'b1000});
    run_op(4'd1, 16'hFFFF, 16'h0001, "add_wrap2", -1);
    run_op(4'd13, 16'h0, 16'h0, "sbc", -1);
    check("sbc_k", {result, 12'h0, flags}, {16'hFFFF, 12'h0, 4'b0010});
    run_op(4'd3, 16'h1234, 16'h0100, "mul", 5);
    check("mul_k", {result, high}, {16'h3400, 16'h0012});
    check("mul_flags_k", flags, 4'b1100);
    run_op(4'd4, 16'd1000, 16'd7, "div", -1);
    check("div_k", {result, high}, {16'h008E, 16'h0006});
    run_op(4'd4, 16'd5, 16'd0, "div0", -1);
    check("div0_k", {result, high, 12'h0, flags}, {16'hFFFF, 16'h0005, 12'h0, 4'b0100});

    // Reset during DIV iteration 8: abort, no done afterwards.
    opcode = 4'd4; a = 16'd1000; b = 16'd7; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (8) @(negedge CLK);
    #1 RESET = 1'b1;
    #2;
    check("abort_res", result, 0); check("abort_high", high, 0); check("abort_flags", flags, 0);
    check("abort_busy", busy, 0); check("abort_done", done, 0);
    RESET = 1'b0;
    m_res = 16'h0; m_high = 16'h0; m_flags = 4'h0;
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done || busy) quiet++;
    end
    check("abort_quiet", quiet, 0);
    run_op(4'd1, 16'd2, 16'd3, "post_rst", -1);
    check("post_rst_k", result, 16'd5);
    @(negedge CLK);
    check("done_drop", done, 0);

    run_op(4'd14, 16'h8000, 16'd3, "asr", -1);
    check("asr_k", {result, 15'h0, flags[1]}, {16'hF000, 16'h0});
    run_op(4'd9, 16'h8001, 16'd1, "shl", -1);
    check("shl_k", {result, 15'h0, flags[1]}, {16'h0002, 16'h1});
    run_op(4'd10, 16'h1234, 16'd20, "shr_big", -1);
    check("shr_big_k", {result, 15'h0, flags[0]}, {16'h0000, 16'h1});
    run_op(4'd5, 16'hF0F0, 16'h3C3C, "and_b2b", -1);
    run_op(4'd6, 16'hF0F0, 16'h3C3C, "or_b2b", -1);
    run_op(4'd0, 16'h1111, 16'h2222, "nop", -1);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      ia = 16'($urandom);
      ib = 16'($urandom);
      if ((op == 4'd9 || op == 4'd10 || op == 4'd14) && $urandom_range(0, 3) != 0)
        ib = 16'($urandom_range(0, 20));
      if (op == 4'd4 && $urandom_range(0, 3) == 0) ib = 16'h0;
      else if (op == 4'd4 && $urandom_range(0, 1) == 0) ib = 16'($urandom_range(1, 300));
      run_op(op, ia, ib, "rnd", -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
